// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - SZ_* : request size encodings (byte/half/word/illegal)
//   - lsu_state_e : control FSM states
//   - size_nbytes() : number of bytes moved for a size code
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Illegal size maps to 4; the FSM never issues an access for it.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    logic [2:0] nb;
    case (size)
      SZ_BYTE: nb = 3'd1;
      SZ_HALF: nb = 3'd2;
      default: nb = 3'd4;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/lsu_align_m.sv
// lsu_align_m: combinational data alignment for the load/store unit.
// Ports:
//   size_i, off_i, signed_i : request size, byte offset in word, sign-extend flag
//   wdata_i                 : right-justified store data
//   word_a_i, word_b_i      : low / high memory words for a load
//   wdata_a_o, strb_a_o     : write data and byte strobes for word A
//   wdata_b_o, strb_b_o     : write data and byte strobes for word B
//   split_o                 : access straddles a word boundary
//   rdata_o                 : merged and extended load result
module lsu_align_m
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_a_i,
  input  logic [31:0] word_b_i,
  output logic [31:0] wdata_a_o,
  output logic [31:0] wdata_b_o,
  output logic [3:0]  strb_a_o,
  output logic [3:0]  strb_b_o,
  output logic        split_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  nbytes;
  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [4:0]  shamt;
  logic [63:0] st_shift;
  logic [31:0] ld_raw;

  assign shamt     = {off_i, 3'b000};
  assign nbytes    = size_nbytes(size_i);
  assign base_mask = 4'((5'd1 << nbytes) - 5'd1);

  // An 8-bit strobe window spanning words A and B; the upper half is word B.
  assign mask8    = {4'b0000, base_mask} << off_i;
  assign st_shift = {32'd0, wdata_i} << shamt;

  assign wdata_a_o = st_shift[31:0];
  assign wdata_b_o = st_shift[63:32];
  assign strb_a_o  = mask8[3:0];
  assign strb_b_o  = mask8[7:4];
  // Derived from the high strobes so a split never issues an empty access.
  assign split_o   = |mask8[7:4];

  // Requested bytes land at the bottom after shifting the word pair down.
  assign ld_raw = 32'({word_b_i, word_a_i} >> shamt);

  always_comb begin
    rdata_o = ld_raw;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & ld_raw[7]}}, ld_raw[7:0]};
      SZ_HALF: rdata_o = {{16{signed_i & ld_raw[15]}}, ld_raw[15:0]};
      SZ_WORD: rdata_o = ld_raw;
      default: rdata_o = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_m.sv
// load_store_m: processor-side load/store unit for the data memory.
// Takes one request at a time, issues one or two aligned word accesses
// with byte strobes, and returns a single one-cycle response.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_write/size/signed/addr/wdata : request fields
//   resp_valid/resp_rdata/resp_err   : one-cycle response
//   mem_read/mem_write/mem_addr/mem_wdata/mem_wstrb : word access, held until mem_ready
//   mem_rdata/mem_ready         : memory read data and completion
module load_store_m
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  lsu_state_e state_q, state_d;

  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       word_a_q, word_a_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;

  // Aligner sees the live request while idle (so word A is ready on the
  // strobe cycle) and the latched request afterwards.
  logic        idle;
  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic        al_signed;
  logic [31:0] al_wdata;
  logic [31:0] al_word_a;
  logic [31:0] al_wdata_a, al_wdata_b;
  logic [3:0]  al_strb_a, al_strb_b;
  logic        al_split;
  logic [31:0] al_rdata;

  assign idle      = (state_q == IDLE);
  assign al_size   = idle ? req_size   : size_q;
  assign al_off    = idle ? req_addr[1:0] : off_q;
  assign al_signed = idle ? req_signed : signed_q;
  assign al_wdata  = idle ? req_wdata  : wdata_q;
  // Word A comes straight from memory when the load completes in ACC0.
  assign al_word_a = (state_q == ACC0) ? mem_rdata : word_a_q;

  lsu_align_m u_align (
    .size_i    (al_size),
    .off_i     (al_off),
    .signed_i  (al_signed),
    .wdata_i   (al_wdata),
    .word_a_i  (al_word_a),
    .word_b_i  (mem_rdata),
    .wdata_a_o (al_wdata_a),
    .wdata_b_o (al_wdata_b),
    .strb_a_o  (al_strb_a),
    .strb_b_o  (al_strb_b),
    .split_o   (al_split),
    .rdata_o   (al_rdata)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    word_a_d     = word_a_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          size_d      = req_size;
          signed_d    = req_signed;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (req_size == SZ_ILL) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ACC0;
            mem_read_d  = !req_write;
            mem_write_d = req_write;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = req_write ? al_wdata_a : '0;
            mem_wstrb_d = req_write ? al_strb_a  : 4'b0000;
          end
        end
      end
      ACC0: begin
        if (mem_ready) begin
          word_a_d = mem_rdata;
          if (al_split) begin
            // Strobe stays high; only address, data and strobes move on.
            state_d     = ACC1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wdata_d = write_q ? al_wdata_b : '0;
            mem_wstrb_d = write_q ? al_strb_b  : 4'b0000;
          end else begin
            state_d      = RESP;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_addr_d   = '0;
            mem_wdata_d  = '0;
            mem_wstrb_d  = 4'b0000;
            resp_valid_d = 1'b1;
            resp_rdata_d = write_q ? '0 : al_rdata;
          end
        end
      end
      ACC1: begin
        if (mem_ready) begin
          state_d      = RESP;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          mem_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : al_rdata;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        req_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      word_a_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      word_a_q     <= word_a_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_m.sv
module tb_load_store_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  load_store_m #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // Memory model: 64 words indexed by addr[7:2], configurable wait states.
  logic [31:0] mem [0:63];
  int wait_cfg = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  assign mem_ready = (mem_read || mem_write) && (wait_cnt == wait_cfg);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read || mem_write) wait_cnt <= mem_ready ? 0 : wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Monitor: sampled on the falling edge, between active edges.
  logic [31:0] log_addr  [0:31];
  logic        log_we    [0:31];
  logic [3:0]  log_strb  [0:31];
  logic [31:0] log_wdata [0:31];
  int acc_total = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int stab_err = 0;
  logic [31:0] resp_rdata_s = 32'd0;
  logic        resp_err_s = 1'b0;
  logic        prev_pend = 1'b0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
  logic [3:0]  prev_strb = 4'd0;

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt     <= resp_cnt + 1;
      resp_rdata_s <= resp_rdata;
      resp_err_s   <= resp_err;
      resp_cyc     <= cyc;
    end
    if ((mem_read || mem_write) && mem_ready) begin
      log_addr[acc_total[4:0]]  <= mem_addr;
      log_we[acc_total[4:0]]    <= mem_write;
      log_strb[acc_total[4:0]]  <= mem_wstrb;
      log_wdata[acc_total[4:0]] <= mem_wdata;
      acc_total <= acc_total + 1;
    end
    if (prev_pend && (mem_read || mem_write)) begin
      if (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wstrb !== prev_strb ||
          mem_read !== prev_rd || mem_write !== prev_wr)
        stab_err <= stab_err + 1;
    end
    prev_pend  <= (mem_read || mem_write) && !mem_ready;
    prev_rd    <= mem_read;
    prev_wr    <= mem_write;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_strb  <= mem_wstrb;
  end

  // Drive one request, wait (bounded) for its response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int acc0, output int t_acc, output int r0, output logic got);
    int n;
    @(negedge clk); #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    acc0 = acc_total;
    r0 = resp_cnt;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    t_acc = cyc;
    @(negedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt == r0 && n < 50) begin @(negedge clk); #1; n++; end
    got = (resp_cnt != r0);
    $display("txn we=%0b size=%0d signed=%0b addr=%08h wdata=%08h -> resp=%0b rdata=%08h err=%0b accesses=%0d latency=%0d",
             w, sz, sg, a, wd, got, resp_rdata_s, resp_err_s, acc_total - acc0, resp_cyc - t_acc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b, expected 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_resp: got valid=%0b err=%0b rdata=%08h, expected all 0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb} !== 70'd0) begin
      errors++; $display("FAIL reset_mem: got rd=%0b wr=%0b addr=%08h wdata=%08h strb=%04b, expected all 0",
                         mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned_load();
    int acc0, t_acc, r0; logic got;
    wait_cfg = 0;
    mem[0] = 32'h4433_2211;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL aligned_resp: got %0b, expected 1", got); end
    checks++;
    if (resp_rdata_s !== 32'h4433_2211) begin errors++; $display("FAIL aligned_rdata: got %08h, expected 44332211", resp_rdata_s); end
    checks++;
    if (resp_err_s !== 1'b0) begin errors++; $display("FAIL aligned_err: got %0b, expected 0", resp_err_s); end
    checks++;
    if (resp_cyc - t_acc != 2) begin errors++; $display("FAIL aligned_latency: got %0d, expected 2", resp_cyc - t_acc); end
    checks++;
    if (acc_total - acc0 != 1) begin errors++; $display("FAIL aligned_count: got %0d accesses, expected 1", acc_total - acc0); end
    checks++;
    if (log_addr[acc0 & 31] !== 32'h100 || log_we[acc0 & 31] !== 1'b0) begin
      errors++; $display("FAIL aligned_access: got addr=%08h we=%0b, expected 00000100 read", log_addr[acc0 & 31], log_we[acc0 & 31]);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (resp_cnt - r0 != 1) begin errors++; $display("FAIL aligned_pulse: got %0d responses, expected 1", resp_cnt - r0); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL aligned_ready: got %0b, expected 1", req_ready); end
  endtask

  task automatic test_split_load();
    int acc0, t_acc, r0; logic got;
    wait_cfg = 0;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1 || resp_rdata_s !== 32'h6655_4433) begin
      errors++; $display("FAIL split_rdata: got resp=%0b rdata=%08h, expected 66554433", got, resp_rdata_s);
    end
    checks++;
    if (resp_cyc - t_acc != 3) begin errors++; $display("FAIL split_latency: got %0d, expected 3", resp_cyc - t_acc); end
    checks++;
    if (acc_total - acc0 != 2 || log_addr[acc0 & 31] !== 32'h100 || log_addr[(acc0 + 1) & 31] !== 32'h104) begin
      errors++; $display("FAIL split_addrs: got n=%0d %08h %08h, expected 2 accesses 00000100 00000104",
                         acc_total - acc0, log_addr[acc0 & 31], log_addr[(acc0 + 1) & 31]);
    end
  endtask

  task automatic test_byte_half_load();
    int acc0, t_acc, r0; logic got;
    wait_cfg = 0;
    mem[0] = 32'h80FF_7F01;
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1 || resp_rdata_s !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL byte_signed: got %08h, expected ffffff80", resp_rdata_s);
    end
    checks++;
    if (resp_cyc - t_acc != 2 || acc_total - acc0 != 1) begin
      errors++; $display("FAIL byte_access: got latency=%0d n=%0d, expected 2 and 1", resp_cyc - t_acc, acc_total - acc0);
    end
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1 || resp_rdata_s !== 32'h0000_0080) begin
      errors++; $display("FAIL byte_unsigned: got %08h, expected 00000080", resp_rdata_s);
    end
    issue(1'b0, 2'd1, 1'b1, 32'h101, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1 || resp_rdata_s !== 32'hFFFF_FF7F) begin
      errors++; $display("FAIL half_signed: got %08h, expected ffffff7f", resp_rdata_s);
    end
  endtask

  task automatic test_store();
    int acc0, t_acc, r0; logic got; int i0, i1;
    wait_cfg = 0;
    issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000_BEEF, acc0, t_acc, r0, got);
    i0 = acc0 & 31;
    i1 = (acc0 + 1) & 31;
    checks++;
    if (got !== 1'b1 || resp_rdata_s !== 32'd0 || resp_err_s !== 1'b0) begin
      errors++; $display("FAIL store_resp: got resp=%0b rdata=%08h err=%0b, expected 1 00000000 0", got, resp_rdata_s, resp_err_s);
    end
    checks++;
    if (acc_total - acc0 != 2) begin errors++; $display("FAIL store_count: got %0d, expected 2", acc_total - acc0); end
    checks++;
    if (log_addr[i0] !== 32'h100 || log_we[i0] !== 1'b1 || log_strb[i0] !== 4'b1000 || log_wdata[i0] !== 32'hEF00_0000) begin
      errors++; $display("FAIL store_word_a: got addr=%08h we=%0b strb=%04b wdata=%08h, expected 00000100 1 1000 ef000000",
                         log_addr[i0], log_we[i0], log_strb[i0], log_wdata[i0]);
    end
    checks++;
    if (log_addr[i1] !== 32'h104 || log_we[i1] !== 1'b1 || log_strb[i1] !== 4'b0001 || log_wdata[i1] !== 32'h0000_00BE) begin
      errors++; $display("FAIL store_word_b: got addr=%08h we=%0b strb=%04b wdata=%08h, expected 00000104 1 0001 000000be",
                         log_addr[i1], log_we[i1], log_strb[i1], log_wdata[i1]);
    end
    issue(1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFE_F00D, acc0, t_acc, r0, got);
    i0 = acc0 & 31;
    checks++;
    if (acc_total - acc0 != 1 || log_addr[i0] !== 32'h108 || log_strb[i0] !== 4'b1111 || log_wdata[i0] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL store_word: got n=%0d addr=%08h strb=%04b wdata=%08h, expected 1 00000108 1111 cafef00d",
                         acc_total - acc0, log_addr[i0], log_strb[i0], log_wdata[i0]);
    end
  endtask

  task automatic test_wrap_waits();
    int acc0, t_acc, r0, s0; logic got;
    mem[63] = 32'h4433_2211;
    mem[0]  = 32'h8877_6655;
    wait_cfg = 2;
    s0 = stab_err;
    issue(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1 || resp_rdata_s !== 32'h7766_5544) begin
      errors++; $display("FAIL wrap_rdata: got resp=%0b rdata=%08h, expected 77665544", got, resp_rdata_s);
    end
    checks++;
    if (acc_total - acc0 != 2 || log_addr[acc0 & 31] !== 32'hFFFF_FFFC || log_addr[(acc0 + 1) & 31] !== 32'h0) begin
      errors++; $display("FAIL wrap_addrs: got n=%0d %08h %08h, expected 2 fffffffc 00000000",
                         acc_total - acc0, log_addr[acc0 & 31], log_addr[(acc0 + 1) & 31]);
    end
    checks++;
    if (resp_cyc - t_acc != 7) begin errors++; $display("FAIL wrap_latency: got %0d, expected 7", resp_cyc - t_acc); end
    checks++;
    if (stab_err != s0) begin errors++; $display("FAIL wrap_stable: got %0d changes during waits, expected 0", stab_err - s0); end
    wait_cfg = 0;
  endtask

  task automatic test_illegal();
    int acc0, t_acc, r0; logic got;
    wait_cfg = 0;
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, acc0, t_acc, r0, got);
    checks++;
    if (got !== 1'b1 || resp_err_s !== 1'b1) begin
      errors++; $display("FAIL illegal_err: got resp=%0b err=%0b, expected 1 1", got, resp_err_s);
    end
    checks++;
    if (acc_total - acc0 != 0) begin errors++; $display("FAIL illegal_noaccess: got %0d accesses, expected 0", acc_total - acc0); end
  endtask

  task automatic test_reset_mid();
    int n, r0;
    wait_cfg = 3;
    @(negedge clk); #1;
    r0 = resp_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h102;
    @(negedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(mem_read && mem_addr == 32'h104) && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (!(mem_read === 1'b1 && mem_addr === 32'h104)) begin
      errors++; $display("FAIL rstmid_acc1: got rd=%0b addr=%08h, expected 1 00000104", mem_read, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rstmid_strobe: got %0b, expected 0", mem_read); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    $display("txn reset during second access -> responses=%0d ready=%0b", resp_cnt - r0, req_ready);
    checks++;
    if (resp_cnt != r0) begin errors++; $display("FAIL rstmid_noresp: got %0d responses, expected 0", resp_cnt - r0); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b, expected 1", req_ready); end
    wait_cfg = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    test_reset();
    test_aligned_load();
    test_split_load();
    test_byte_half_load();
    test_store();
    test_wrap_waits();
    test_illegal();
    test_reset_mid();
    test_aligned_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
